// File: rtl/pipeline_pkg.sv
// Shared constants for the MIPS pipeline hazard controller:
// FSM state encoding, the zero register index and default sizing.
package pipeline_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_COUNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc high and
// sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next value: step by one unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline:
// load-use stalls, branch flushes, memory wait freeze and watchdog.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         idRs,
    input  logic [4:0]         idRt,
    input  logic               idUsesRt,
    input  logic               exMemRead,
    input  logic [4:0]         exRt,
    input  logic               memBranchTaken,
    input  logic               memAccess,
    input  logic               dmemReady,
    output logic               pcWrite,
    output logic               ifidWrite,
    output logic               idexWrite,
    output logic               exmemWrite,
    output logic               memwbWrite,
    output logic               ifidFlush,
    output logic               idexBubble,
    output logic               exmemBubble,
    output logic               memTimeout,
    output logic [COUNT_W-1:0] stallCount,
    output logic [COUNT_W-1:0] flushCount,
    output logic [COUNT_W-1:0] waitCount
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [TW-1:0] timer_inc;
    logic          timeout_q;
    logic          timeout_d;

    logic load_use;
    logic freeze;
    logic do_stall;
    logic do_flush;
    logic do_wait;

    assign load_use = exMemRead && (exRt != REG_ZERO) &&
                      ((exRt == idRs) || (idUsesRt && (exRt == idRt)));

    assign timer_inc = timer_q + TW'(1);

    // Freeze request: new miss in RUN, or memory still busy in WAIT
    always_comb begin
        freeze = 1'b0;
        unique case (state_q)
            ST_RUN:  freeze = memAccess && !dmemReady;
            ST_WAIT: freeze = !dmemReady;
            default: freeze = 1'b0;
        endcase
    end

    // Per-cycle pipeline controls, highest priority first
    always_comb begin
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        idexWrite   = 1'b1;
        exmemWrite  = 1'b1;
        memwbWrite  = 1'b1;
        ifidFlush   = 1'b0;
        idexBubble  = 1'b0;
        exmemBubble = 1'b0;
        do_stall    = 1'b0;
        do_flush    = 1'b0;
        do_wait     = 1'b0;
        if (!rst_n) begin
            pcWrite     = 1'b0;
            ifidFlush   = 1'b1;
            idexBubble  = 1'b1;
            exmemBubble = 1'b1;
        end else if ((state_q == ST_FAULT) || freeze) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            memwbWrite = 1'b0;
            do_wait    = (state_q != ST_FAULT);
        end else if (memBranchTaken) begin
            ifidFlush   = 1'b1;
            idexBubble  = 1'b1;
            exmemBubble = 1'b1;
            do_flush    = 1'b1;
        end else if (load_use) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
            do_stall   = 1'b1;
        end
    end

    // Wait sequencing and watchdog next state
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ST_RUN: begin
                if (memAccess && !dmemReady) begin
                    state_d = ST_WAIT;
                    timer_d = TW'(1);
                end
            end
            ST_WAIT: begin
                if (dmemReady) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                end else if (timer_inc == TW'(TIMEOUT)) begin
                    state_d   = ST_FAULT;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_FAULT: begin
                timeout_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                timer_d = '0;
            end
        endcase
    end

    // State, timer and sticky fault registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign memTimeout = timeout_q;

    sat_counter #(.W(COUNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_stall),
        .count (stallCount)
    );

    sat_counter #(.W(COUNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_flush),
        .count (flushCount)
    );

    sat_counter #(.W(COUNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_wait),
        .count (waitCount)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then
// random traffic against a behavioural model.
module tb_hazard_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] idRs, idRt, exRt;
    logic       idUsesRt, exMemRead, memBranchTaken;
    logic       memAccess, dmemReady;

    logic        pcW, ifidW, idexW, exmemW, memwbW;
    logic        ifidF, idexB, exmemB, tmo;
    logic [15:0] stC, flC, wtC;

    logic        pcW2, ifidW2, idexW2, exmemW2, memwbW2;
    logic        ifidF2, idexB2, exmemB2, tmo2;
    logic [1:0]  stC2, flC2, wtC2;

    int checks = 0;
    int failures = 0;

    bit m_wait, m_fault;
    int m_n, m_stall, m_flush, m_wcnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(TO), .COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .idRs(idRs), .idRt(idRt),
        .idUsesRt(idUsesRt), .exMemRead(exMemRead), .exRt(exRt),
        .memBranchTaken(memBranchTaken), .memAccess(memAccess),
        .dmemReady(dmemReady), .pcWrite(pcW), .ifidWrite(ifidW),
        .idexWrite(idexW), .exmemWrite(exmemW), .memwbWrite(memwbW),
        .ifidFlush(ifidF), .idexBubble(idexB), .exmemBubble(exmemB),
        .memTimeout(tmo), .stallCount(stC), .flushCount(flC),
        .waitCount(wtC)
    );

    hazard_ctrl #(.TIMEOUT(TO), .COUNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .idRs(idRs), .idRt(idRt),
        .idUsesRt(idUsesRt), .exMemRead(exMemRead), .exRt(exRt),
        .memBranchTaken(memBranchTaken), .memAccess(memAccess),
        .dmemReady(dmemReady), .pcWrite(pcW2), .ifidWrite(ifidW2),
        .idexWrite(idexW2), .exmemWrite(exmemW2), .memwbWrite(memwbW2),
        .ifidFlush(ifidF2), .idexBubble(idexB2), .exmemBubble(exmemB2),
        .memTimeout(tmo2), .stallCount(stC2), .flushCount(flC2),
        .waitCount(wtC2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic clear_in();
        idRs = 5'd0; idRt = 5'd0; exRt = 5'd0;
        idUsesRt = 1'b0; exMemRead = 1'b0; memBranchTaken = 1'b0;
        memAccess = 1'b0; dmemReady = 1'b1;
    endtask

    task automatic model_reset();
        m_wait = 0; m_fault = 0; m_n = 0;
        m_stall = 0; m_flush = 0; m_wcnt = 0;
    endtask

    // One clock: check outputs at negedge, advance model at posedge
    task automatic step();
        bit lu, br, fz;
        logic [7:0] ctl;
        @(negedge clk);
        lu = exMemRead && exRt != 0 &&
             (exRt == idRs || (idUsesRt && exRt == idRt));
        br = memBranchTaken;
        fz = m_wait ? !dmemReady : (memAccess && !dmemReady);
        if (!rst_n)       ctl = 8'b0111_1111;
        else if (m_fault) ctl = 8'b0000_0000;
        else if (fz)      ctl = 8'b0000_0000;
        else if (br)      ctl = 8'b1111_1111;
        else if (lu)      ctl = 8'b0011_1010;
        else              ctl = 8'b1111_1000;
        check("ctl", {24'd0, pcW, ifidW, idexW, exmemW, memwbW,
                      ifidF, idexB, exmemB}, {24'd0, ctl});
        check("ctl_s", {24'd0, pcW2, ifidW2, idexW2, exmemW2, memwbW2,
                        ifidF2, idexB2, exmemB2}, {24'd0, ctl});
        check("timeout", {31'd0, tmo}, {31'd0, m_fault});
        check("stallCount", {16'd0, stC}, sat(m_stall, 16));
        check("flushCount", {16'd0, flC}, sat(m_flush, 16));
        check("waitCount", {16'd0, wtC}, sat(m_wcnt, 16));
        check("stallCount_s", {30'd0, stC2}, sat(m_stall, 2));
        check("waitCount_s", {30'd0, wtC2}, sat(m_wcnt, 2));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (!m_fault) begin
            if (fz) begin
                m_wcnt++;
                m_n = m_wait ? m_n + 1 : 1;
                m_wait = 1;
                if (m_n == TO) m_fault = 1;
            end else begin
                m_wait = 0;
                m_n = 0;
                if (br) m_flush++;
                else if (lu) m_stall++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int readyP;
        clear_in();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step();
        rst_n = 1'b1;

        // load-use on rs
        exMemRead = 1'b1; exRt = 5'd2; idRs = 5'd2;
        step();
        clear_in();
        step();
        check("lu_stall1", {16'd0, stC}, 32'd1);

        // no stall: rt is zero / rt match but not used
        exMemRead = 1'b1; exRt = 5'd0; idRs = 5'd0;
        step();
        exRt = 5'd3; idRt = 5'd3; idUsesRt = 1'b0; idRs = 5'd1;
        step();
        clear_in();
        step();
        check("no_stall", {16'd0, stC}, 32'd1);

        // branch flush beats load-use
        do_reset();
        memBranchTaken = 1'b1;
        exMemRead = 1'b1; exRt = 5'd4; idRt = 5'd4; idUsesRt = 1'b1;
        step();
        clear_in();
        step();
        check("br_flush", {16'd0, flC}, 32'd1);
        check("br_nostall", {16'd0, stC}, 32'd0);

        // three wait cycles then ready
        do_reset();
        memAccess = 1'b1; dmemReady = 1'b0;
        step();
        memAccess = 1'b0;
        step();
        step();
        dmemReady = 1'b1;
        step();
        clear_in();
        step();
        check("wait3", {16'd0, wtC}, 32'd3);
        check("wait3_tmo", {31'd0, tmo}, 32'd0);

        // watchdog fault, then recovery through reset
        do_reset();
        memAccess = 1'b1; dmemReady = 1'b0;
        repeat (6) step();
        check("fault_tmo", {31'd0, tmo}, 32'd1);
        check("fault_wait", {16'd0, wtC}, 32'd4);
        do_reset();
        step();
        check("rec_tmo", {31'd0, tmo}, 32'd0);
        check("rec_wait", {16'd0, wtC}, 32'd0);

        // saturation of a 2-bit counter
        do_reset();
        exMemRead = 1'b1; exRt = 5'd7; idRs = 5'd7;
        repeat (5) step();
        clear_in();
        step();
        check("sat_stall", {30'd0, stC2}, 32'd3);
        check("nosat_stall", {16'd0, stC}, 32'd5);

        // random traffic
        do_reset();
        readyP = 5;
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) readyP = $urandom_range(0, 2) * 4 + 1;
            rst_n = ($urandom_range(0, 59) != 0);
            idRs = 5'($urandom_range(0, 3));
            idRt = 5'($urandom_range(0, 3));
            exRt = 5'($urandom_range(0, 3));
            idUsesRt = 1'($urandom_range(0, 1));
            exMemRead = 1'($urandom_range(0, 1));
            memBranchTaken = ($urandom_range(0, 4) == 0);
            memAccess = ($urandom_range(0, 3) == 0);
            dmemReady = ($urandom_range(0, 9) < readyP);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
